// File: rtl/sdram_host_pkg.sv
// Shared types and sizing helpers for the SDRAM host-side request port.
package sdram_host_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ACTIVE
  } state_t;

  // Request FIFO entry is {write, addr, wdata}.
  function automatic int entry_w(input int aw);
    return 1 + aw + DATA_W;
  endfunction

  function automatic int tmo_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sdram_host_fifo.sv
// Small synchronous request FIFO; head is read straight from the storage registers.
module sdram_host_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr, r_rptr;
  logic             w_wr, w_rd;

  assign w_wr = i_push && !o_full;
  assign w_rd = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_dout  = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/sdram_host_port.sv
// Host valid/ready front end that replays buffered requests onto the controller's
// level-sensitive enable/busy handshake and returns read data on a response channel.
module sdram_host_port
  import sdram_host_pkg::*;
#(
  parameter int HADDR_WIDTH    = 24,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [HADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   port_idle,
  output logic                   timeout_err,
  output logic [HADDR_WIDTH-1:0] wr_addr,
  output logic [HADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   wr_enable,
  output logic                   rd_enable,
  input  logic [DATA_W-1:0]      rd_data,
  input  logic                   rd_ready,
  input  logic                   busy
);

  localparam int EW = entry_w(HADDR_WIDTH);
  localparam int TW = tmo_w(TIMEOUT_CYCLES);

  typedef struct packed {
    logic                   write;
    logic [HADDR_WIDTH-1:0] addr;
    logic [DATA_W-1:0]      wdata;
  } req_t;

  state_t                 r_state, w_next;
  req_t                   w_head;
  logic [EW-1:0]          w_push_ent;
  logic                   w_push, w_pop, w_full, w_empty;
  logic                   w_tmo, w_can_issue;
  logic [TW-1:0]          r_tmo;
  logic                   r_is_rd, r_seen;
  logic                   r_wr_en, r_rd_en, r_rsp_valid, r_terr;
  logic [HADDR_WIDTH-1:0] r_addr;
  logic [DATA_W-1:0]      r_wdata, r_rsp_data;

  assign w_push_ent = {req_write, req_addr, req_wdata};
  assign w_push     = req_valid && !w_full;
  assign w_pop      = (r_state == ST_ISSUE) && (busy || w_tmo);

  sdram_host_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_push_ent),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A read waits while a response is still pending so responses never overflow.
  assign w_can_issue = !w_empty && (w_head.write || !r_rsp_valid);
  assign w_tmo       = (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_can_issue) w_next = ST_ISSUE;
      ST_ISSUE:  if (busy) w_next = ST_ACTIVE;
                 else if (w_tmo) w_next = ST_IDLE;
      ST_ACTIVE: if (!busy || w_tmo) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_terr      <= 1'b0;
      r_tmo       <= '0;
      r_is_rd     <= 1'b0;
      r_seen      <= 1'b0;
    end else begin
      if (r_rsp_valid && rsp_ready) r_rsp_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: if (w_can_issue) begin
          r_addr  <= w_head.addr;
          r_wdata <= w_head.wdata;
          r_wr_en <= w_head.write;
          r_rd_en <= !w_head.write;
          r_is_rd <= !w_head.write;
          r_seen  <= 1'b0;
          r_tmo   <= '0;
        end
        // Low busy here may just be a refresh in progress; keep holding until the timeout.
        ST_ISSUE: begin
          r_tmo <= r_tmo + 1'b1;
          if (busy || w_tmo) begin
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
          end
          if (!busy && w_tmo) r_terr <= 1'b1;
        end
        ST_ACTIVE: begin
          r_tmo <= r_tmo + 1'b1;
          if (r_is_rd && rd_ready) begin
            r_rsp_data  <= rd_data;
            r_rsp_valid <= 1'b1;
            r_seen      <= 1'b1;
          end
          if (!busy) begin
            if (r_is_rd && !r_seen && !rd_ready) r_terr <= 1'b1;
          end else if (w_tmo) begin
            r_terr <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = !w_full;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign timeout_err = r_terr;
  assign wr_enable   = r_wr_en;
  assign rd_enable   = r_rd_en;
  assign wr_addr     = r_addr;
  assign rd_addr     = r_addr;
  assign wr_data     = r_wdata;
  assign port_idle   = w_empty && (r_state == ST_IDLE) && !r_rsp_valid;

endmodule

// File: tb/tb_sdram_host_port.sv
// Directed bench for sdram_host_port against a small behavioural controller stub.
module tb_sdram_host_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [23:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready, rsp_valid, port_idle, timeout_err, wr_enable, rd_enable;
  logic [15:0] rsp_data, wr_data, rd_data;
  logic [23:0] wr_addr, rd_addr;
  logic        rd_ready, busy;

  int errors = 0;
  int checks = 0;

  sdram_host_port dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .port_idle(port_idle), .timeout_err(timeout_err), .wr_addr(wr_addr),
    .rd_addr(rd_addr), .wr_data(wr_data), .wr_enable(wr_enable), .rd_enable(rd_enable),
    .rd_data(rd_data), .rd_ready(rd_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Controller stub: latches a request when idle, busy for 4 cycles, read data
  // pulse on the last busy cycle. hold mimics refresh, stuck never accepts.
  logic        hold = 1'b0, stuck = 1'b0;
  logic [15:0] smem [256];
  logic [40:0] log_q [$];
  int          cnt;
  logic        c_wr;
  logic [23:0] c_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0; rd_ready <= 1'b0; rd_data <= '0; cnt <= 0; c_wr <= 1'b0; c_addr <= '0;
    end else begin
      rd_ready <= 1'b0;
      if (busy) begin
        if (cnt == 0) busy <= 1'b0;
        else begin
          cnt <= cnt - 1;
          if (cnt == 1 && !c_wr) begin
            rd_ready <= 1'b1;
            rd_data  <= smem[c_addr[7:0]];
          end
        end
      end else if (!hold && !stuck && (wr_enable || rd_enable)) begin
        busy   <= 1'b1;
        cnt    <= 3;
        c_wr   <= wr_enable;
        c_addr <= wr_enable ? wr_addr : rd_addr;
        if (wr_enable) smem[wr_addr[7:0]] <= wr_data;
        log_q.push_back({wr_enable, wr_enable ? wr_addr : rd_addr, wr_enable ? wr_data : 16'h0});
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic push(input logic w, input logic [23:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < 400) begin @(negedge clk); n++; end
    if (!req_ready) chk("push_wait", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input string nm, input logic [15:0] exp);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 1000) begin @(negedge clk); n++; end
    if (!rsp_valid) chk({nm, "_wait"}, rsp_valid, 1'b1);
    chk({nm, "_data"}, rsp_data, exp);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_clr"}, rsp_valid, 1'b0);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while (!port_idle && n < 1000) begin @(negedge clk); n++; end
    if (!port_idle) chk({nm, "_idle"}, port_idle, 1'b1);
  endtask

  typedef struct {
    logic        w;
    logic [23:0] a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl [8];
  logic [40:0] e;
  int          n;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 24'h001234, 16'hBEEF, 16'h0};
    tbl[1] = '{1'b0, 24'h001234, 16'h0,    16'hBEEF};
    tbl[2] = '{1'b1, 24'h000055, 16'hA5A5, 16'h0};
    tbl[3] = '{1'b1, 24'h0000FF, 16'h0001, 16'h0};
    tbl[4] = '{1'b0, 24'h000055, 16'h0,    16'hA5A5};
    tbl[5] = '{1'b0, 24'h0000FF, 16'h0,    16'h0001};
    tbl[6] = '{1'b1, 24'h001234, 16'h0000, 16'h0};
    tbl[7] = '{1'b0, 24'h001234, 16'h0,    16'h0000};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_wr_en", wr_enable, 1'b0);
    chk("rst_rd_en", rd_enable, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_terr", timeout_err, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_addr", wr_addr, 24'h0);
    chk("rst_idle", port_idle, 1'b1);
    rst_n = 1'b1;

    // Issue latency and enable hold through the first busy cycle
    push(1'b1, 24'h000010, 16'h1111);
    @(negedge clk); chk("lat_n0", wr_enable, 1'b0);
    @(negedge clk); chk("lat_n1", wr_enable, 1'b1);
    chk("lat_addr", wr_addr, 24'h000010);
    chk("lat_data", wr_data, 16'h1111);
    @(negedge clk); chk("hold_busy_lag", wr_enable, 1'b1);
    @(negedge clk); chk("drop_after_busy", wr_enable, 1'b0);
    wait_idle("lat");
    log_q.delete();

    // Table-driven single transactions
    for (int i = 0; i < 8; i++) begin
      push(tbl[i].w, tbl[i].a, tbl[i].d);
      if (!tbl[i].w) get_rsp($sformatf("vec%0d", i), tbl[i].exp);
      wait_idle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_terr", i), timeout_err, 1'b0);
      e = {tbl[i].w, tbl[i].a, tbl[i].w ? tbl[i].d : 16'h0};
      chk($sformatf("vec%0d_logn", i), 64'(log_q.size()), 64'd1);
      if (log_q.size() > 0) chk($sformatf("vec%0d_log", i), log_q.pop_front(), e);
    end

    // FIFO full: 4 writes held off, 5th stalls until the first pop
    log_q.delete();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b1, 24'(32 + i), 16'(16'hF000 + i));
    @(negedge clk); chk("full_ready", req_ready, 1'b0);
    fork
      push(1'b1, 24'd36, 16'hF004);
      begin
        repeat (5) @(negedge clk);
        chk("full_stall", req_ready, 1'b0);
        hold = 1'b0;
      end
    join
    wait_idle("full");
    chk("full_logn", 64'(log_q.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (log_q.size() > 0) chk($sformatf("full_ord%0d", i), log_q.pop_front(), {1'b1, 24'(32 + i), 16'(16'hF000 + i)});

    // Read held across a controller refresh window
    push(1'b1, 24'h000077, 16'hC0DE);
    wait_idle("ref_w");
    hold = 1'b1;
    push(1'b0, 24'h000077, 16'h0);
    repeat (30) @(negedge clk);
    chk("ref_hold_en", rd_enable, 1'b1);
    chk("ref_terr", timeout_err, 1'b0);
    hold = 1'b0;
    get_rsp("ref", 16'hC0DE);
    wait_idle("ref");
    chk("ref_terr_end", timeout_err, 1'b0);

    // Response backpressure blocks the second read
    log_q.delete();
    push(1'b0, 24'h000055, 16'h0);
    push(1'b0, 24'h0000FF, 16'h0);
    repeat (20) @(negedge clk);
    chk("bp_valid", rsp_valid, 1'b1);
    chk("bp_data", rsp_data, 16'hA5A5);
    chk("bp_rd_en", rd_enable, 1'b0);
    chk("bp_one_issued", 64'(log_q.size()), 64'd1);
    get_rsp("bp0", 16'hA5A5);
    get_rsp("bp1", 16'h0001);
    wait_idle("bp");
    chk("bp_two_issued", 64'(log_q.size()), 64'd2);

    // Timeout: controller never accepts; request dropped after 255 cycles
    stuck = 1'b1;
    push(1'b1, 24'h000010, 16'h2222);
    n = 0;
    while (!wr_enable && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (wr_enable && n < 400) begin n++; @(negedge clk); end
    chk("tmo_cycles", 64'(n), 64'd255);
    chk("tmo_en_low", wr_enable, 1'b0);
    chk("tmo_err", timeout_err, 1'b1);
    stuck = 1'b0;
    push(1'b0, 24'h000010, 16'h0);
    get_rsp("tmo_next", 16'h1111);
    wait_idle("tmo");
    chk("tmo_sticky", timeout_err, 1'b1);

    // Asynchronous reset in the middle of ISSUE
    hold = 1'b1;
    push(1'b0, 24'h000055, 16'h0);
    push(1'b1, 24'h000056, 16'h5656);
    repeat (3) @(negedge clk);
    chk("mid_issue_en", rd_enable, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_en", rd_enable, 1'b0);
    chk("mid_rst_rsp", rsp_valid, 1'b0);
    chk("mid_rst_terr", timeout_err, 1'b0);
    chk("mid_rst_ready", req_ready, 1'b1);
    chk("mid_rst_idle", port_idle, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    hold = 1'b0;
    push(1'b0, 24'h000055, 16'h0);
    get_rsp("post_rst", 16'hA5A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
